// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-granular AXI-Stream arbiter: N requesters share one downstream stream.
// Define AXIS_ARB_TID_TAG_EN to replace m_axis_tid with the granted requester index.
module axis_packet_arbiter #(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEST_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS*ID_WIDTH-1:0]   s_axis_tid,
  input  logic [NUM_INPUTS*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [NUM_INPUTS*USER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
  input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
  output logic [NUM_INPUTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic [$clog2(NUM_INPUTS)-1:0]    grant,
  output logic                             busy
);

  localparam int unsigned GrantW = $clog2(NUM_INPUTS);

  typedef enum logic [0:0] {StIdle, StGranted} state_e;

  state_e              state_q, state_d;
  logic [GrantW-1:0]   ptr_q, ptr_d;
  logic [GrantW-1:0]   grant_q, grant_d;
  logic [GrantW-1:0]   sel_idx, sel_c;
  logic                sel_found;
  logic                id_pass_unused;
  logic [ID_WIDTH-1:0] tid_pass;

  // First asserted requester scanning upward from ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_c     = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      sel_c = GrantW'((32'(ptr_q) + k) % NUM_INPUTS);
      if (!sel_found && s_axis_tvalid[sel_c]) begin
        sel_found = 1'b1;
        sel_idx   = sel_c;
      end
    end
  end

  // Sideband always follows the registered grant; only valid/ready are gated by state.
  always_comb begin
    m_axis_tdata  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    tid_pass      = s_axis_tid[grant_q*ID_WIDTH +: ID_WIDTH];
    m_axis_tdest  = s_axis_tdest[grant_q*DEST_WIDTH +: DEST_WIDTH];
    m_axis_tuser  = s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
    m_axis_tlast  = s_axis_tlast[grant_q];
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state_q == StGranted) begin
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

`ifdef AXIS_ARB_TID_TAG_EN
  assign m_axis_tid     = ID_WIDTH'(grant_q);
  assign id_pass_unused = ^tid_pass;
`else
  assign m_axis_tid     = tid_pass;
  assign id_pass_unused = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          grant_d = sel_idx;
          state_d = StGranted;
        end
      end
      StGranted: begin
        // Grant is held until the last beat actually transfers.
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_d = StIdle;
          ptr_d   = (grant_q == GrantW'(NUM_INPUTS - 1)) ? '0 : grant_q + GrantW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == StGranted);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter (4 requesters): directed vector table, hand-written
// reset/tagging sequences and a randomized run against a round-robin packet model.
module tb_axis_packet_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata, s_tid, s_tdest;
  logic [3:0]  s_tuser, s_tvalid, s_tlast, s_tready;
  logic [7:0]  m_tdata, m_tid, m_tdest;
  logic        m_tuser, m_tvalid, m_tlast, m_tready;
  logic [1:0]  grant;
  logic        busy;

  always #5 clk = ~clk;

  axis_packet_arbiter #(
    .NUM_INPUTS(N), .DATA_WIDTH(8), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .grant(grant), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  tv, tl;
    logic [31:0] sd;
    logic        mt, mv;
    logic [7:0]  md;
    logic        ml;
    logic [3:0]  sr;
    logic [1:0]  g;
    logic        b;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] tv, input logic [3:0] tl, input logic [31:0] sd,
                              input logic mt, input logic mv, input logic [7:0] md,
                              input logic ml, input logic [3:0] sr, input logic [1:0] g,
                              input logic b);
    vec_t v;
    v.tv = tv; v.tl = tl; v.sd = sd; v.mt = mt; v.mv = mv;
    v.md = md; v.ml = ml; v.sr = sr; v.g = g; v.b = b;
    return v;
  endfunction

  // Behavioural model: owner of the stream (-1 when idle), round-robin pointer, last grant.
  int owner, mptr, mgrant;
  int beat[N], len[N], seq[N];
  int order[$];
  bit in_pkt;
  int gap;

  task automatic model_reset();
    owner = -1; mptr = 0; mgrant = 0;
    for (int i = 0; i < N; i++) begin beat[i] = 0; len[i] = 2; seq[i] = 0; end
    order.delete(); in_pkt = 0; gap = 0;
  endtask

  task automatic run_model(input int ncyc, input bit rnd, input bit track);
    logic [3:0]  tv, tl, exp_sr;
    logic [31:0] data;
    logic        exp_mv;
    int          o, c;
    for (int cy = 0; cy < ncyc; cy++) begin
      for (int i = 0; i < N; i++) begin
        tv[i] = rnd ? ($urandom_range(0, 9) < 7) : (i < 2);
        tl[i] = (beat[i] == len[i] - 1);
        data[i*8 +: 8] = {i[1:0], seq[i][5:0]};
      end
      s_tvalid = tv; s_tlast = tl; s_tdata = data;
      m_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      exp_sr = '0; exp_mv = 1'b0;
      if (owner >= 0) begin exp_mv = tv[owner]; exp_sr[owner] = m_tready; end
      chk("m_tvalid", m_tvalid, exp_mv);
      chk("s_tready", s_tready, exp_sr);
      chk("grant", grant, mgrant);
      chk("busy", busy, owner >= 0);
      if (exp_mv) begin
        chk("m_tdata", m_tdata, data[owner*8 +: 8]);
        chk("m_tlast", m_tlast, tl[owner]);
        chk("m_tdest", m_tdest, 8'h20 + owner);
`ifdef AXIS_ARB_TID_TAG_EN
        chk("m_tid", m_tid, owner);
`else
        chk("m_tid", m_tid, 8'h10 + owner);
`endif
      end
      if (track) begin
        if (m_tvalid && m_tready) begin
          if (!in_pkt) begin
            if (order.size() > 0) chk("bubble", gap, 1);
            order.push_back(int'(grant));
          end
          in_pkt = !m_tlast;
          gap = 0;
        end else if (!in_pkt) begin
          gap++;
        end
      end
      o = owner;
      if (o < 0) begin
        for (int k = 0; k < N; k++) begin
          c = (mptr + k) % N;
          if (owner < 0 && tv[c]) begin owner = c; mgrant = c; end
        end
      end else if (tv[o] && m_tready) begin
        seq[o]++;
        if (tl[o]) begin
          beat[o] = 0;
          len[o]  = rnd ? int'($urandom_range(1, 4)) : 2;
          mptr    = (o + 1) % N;
          owner   = -1;
        end else begin
          beat[o]++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl[21];

  initial begin
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = 4'b1010; m_tready = 1'b0;
    s_tid = 32'h53525150; s_tdest = 32'h23222120;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_mvalid", m_tvalid, 0);
    chk("reset_sready", s_tready, 0);
    chk("reset_grant", grant, 0);
    rst = 1'b0;

    tbl[0]  = mk(4'h1, 4'h0, 32'h000000A1, 1, 0, 8'h00, 0, 4'h0, 2'd0, 0);
    tbl[1]  = mk(4'h1, 4'h0, 32'h000000A1, 1, 1, 8'hA1, 0, 4'h1, 2'd0, 1);
    tbl[2]  = mk(4'h1, 4'h0, 32'h000000A2, 1, 1, 8'hA2, 0, 4'h1, 2'd0, 1);
    tbl[3]  = mk(4'h1, 4'h1, 32'h000000A3, 1, 1, 8'hA3, 1, 4'h1, 2'd0, 1);
    tbl[4]  = mk(4'h0, 4'h0, 32'h00000000, 1, 0, 8'h00, 0, 4'h0, 2'd0, 0);
    tbl[5]  = mk(4'h1, 4'h0, 32'h000000B1, 1, 0, 8'h00, 0, 4'h0, 2'd0, 0);
    tbl[6]  = mk(4'h3, 4'h0, 32'h0000C1B1, 1, 1, 8'hB1, 0, 4'h1, 2'd0, 1);
    tbl[7]  = mk(4'h3, 4'h1, 32'h0000C1B2, 1, 1, 8'hB2, 1, 4'h1, 2'd0, 1);
    tbl[8]  = mk(4'h2, 4'h0, 32'h0000C100, 1, 0, 8'h00, 0, 4'h0, 2'd0, 0);
    tbl[9]  = mk(4'h2, 4'h2, 32'h0000C100, 1, 1, 8'hC1, 1, 4'h2, 2'd1, 1);
    tbl[10] = mk(4'h0, 4'h0, 32'h00000000, 1, 0, 8'h00, 0, 4'h0, 2'd1, 0);
    tbl[11] = mk(4'h4, 4'h0, 32'h00D10000, 1, 0, 8'h00, 0, 4'h0, 2'd1, 0);
    tbl[12] = mk(4'h4, 4'h0, 32'h00D10000, 1, 1, 8'hD1, 0, 4'h4, 2'd2, 1);
    tbl[13] = mk(4'h4, 4'h0, 32'h00D20000, 0, 1, 8'hD2, 0, 4'h0, 2'd2, 1);
    tbl[14] = mk(4'h4, 4'h0, 32'h00D20000, 1, 1, 8'hD2, 0, 4'h4, 2'd2, 1);
    tbl[15] = mk(4'h0, 4'h0, 32'h00000000, 1, 0, 8'h00, 0, 4'h4, 2'd2, 1);
    tbl[16] = mk(4'h4, 4'h0, 32'h00D30000, 0, 1, 8'hD3, 0, 4'h0, 2'd2, 1);
    tbl[17] = mk(4'h4, 4'h0, 32'h00D30000, 1, 1, 8'hD3, 0, 4'h4, 2'd2, 1);
    tbl[18] = mk(4'h4, 4'h4, 32'h00D40000, 0, 1, 8'hD4, 1, 4'h0, 2'd2, 1);
    tbl[19] = mk(4'h4, 4'h4, 32'h00D40000, 1, 1, 8'hD4, 1, 4'h4, 2'd2, 1);
    tbl[20] = mk(4'h0, 4'h0, 32'h00000000, 1, 0, 8'h00, 0, 4'h0, 2'd2, 0);

    foreach (tbl[r]) begin
      s_tvalid = tbl[r].tv; s_tlast = tbl[r].tl; s_tdata = tbl[r].sd; m_tready = tbl[r].mt;
      #1;
      chk($sformatf("vec%0d_mvalid", r), m_tvalid, tbl[r].mv);
      chk($sformatf("vec%0d_sready", r), s_tready, tbl[r].sr);
      chk($sformatf("vec%0d_grant", r), grant, tbl[r].g);
      chk($sformatf("vec%0d_busy", r), busy, tbl[r].b);
      if (tbl[r].mv) begin
        chk($sformatf("vec%0d_mdata", r), m_tdata, tbl[r].md);
        chk($sformatf("vec%0d_mlast", r), m_tlast, tbl[r].ml);
      end
      @(posedge clk); #1;
    end

    // Reset mid-packet: s1 is granted while ptr=3, reset must abandon it and clear ptr.
    s_tvalid = 4'b0010; s_tlast = 4'b0000; s_tdata = 32'h0000E100; m_tready = 1'b1;
    #1 chk("rst_pre_idle", m_tvalid, 0);
    @(posedge clk); #1;
    chk("rst_pre_grant", grant, 1);
    chk("rst_pre_data", m_tdata, 8'hE1);
    @(posedge clk); #1;
    s_tdata = 32'h0000E200;
    #1 chk("rst_beat2_valid", m_tvalid, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_mvalid", m_tvalid, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_sready", s_tready, 0);
    chk("rst_async_grant", grant, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_tvalid = 4'b1100; s_tlast = 4'b1100; s_tdata = 32'hF3F20000; s_tid = 32'h55525150;
    #1 chk("rst_post_idle", m_tvalid, 0);
    @(posedge clk); #1;
    chk("rst_ptr_zero_grant", grant, 2);
    chk("rst_post_data", m_tdata, 8'hF2);
    @(posedge clk); #1;
    s_tvalid = 4'b1000;
    #1 chk("tag_idle", m_tvalid, 0);
    @(posedge clk); #1;
    chk("tag_grant", grant, 3);
    chk("tag_data", m_tdata, 8'hF3);
`ifdef AXIS_ARB_TID_TAG_EN
    chk("tag_tid", m_tid, 8'h03);
`else
    chk("tag_tid", m_tid, 8'h55);
`endif
    @(posedge clk); #1;
    s_tvalid = 4'b0000;
    #1 chk("tag_done_busy", busy, 0);

    // Two always-valid requesters with 2-beat packets, then randomized traffic.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_tid = 32'h13121110;
    model_reset();
    run_model(12, 1'b0, 1'b1);
    chk("rr_order_len", order.size() >= 4, 1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_order%0d", k), order.size() > k ? order[k] : 99, k % 2);
    run_model(600, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
